// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with the IF/ID pipeline register.
//
// Owns the fetch PC and drives the asynchronous-read instruction memory address.
// It captures the fetched word into the IF/ID register and decodes the opcode and
// imm-flag fields for the decode stage.
//
// Control priority on every edge is rst > flush > stall > normal.
//   - An END opcode halts fetch.
//   - A flush redirects the PC, squashes IF/ID and cancels any halt.
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds the perf_fetch_cnt and
// perf_flush_cnt event counters.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   imem_addr         instruction memory address (the fetch PC register)
//   imem_rdata        instruction word at imem_addr, same cycle
//   stall             hold PC, IF/ID register and state
//   flush             redirect to branch_target and squash IF/ID
//   branch_target     redirect PC, used only when flush=1
//   instr_d           IF/ID instruction register
//   pc_d              PC of instr_d
//   valid_d           instr_d is a real instruction (0 = bubble)
//   operation, imm    opcode and imm flag of instr_d
//   halted            high while fetch is halted on END
//   perf_fetch_cnt    (FETCH_PERF_CNT_EN) count of valid IF/ID loads
//   perf_flush_cnt    (FETCH_PERF_CNT_EN) count of flushes
module fetch_stage #(
  parameter int unsigned       PC_W     = 16,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] instr_d,
  output logic [PC_W-1:0]    pc_d,
  output logic               valid_d,
  output logic [3:0]         operation,
  output logic               imm,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int unsigned      OP_W     = 4;
  localparam logic [OP_W-1:0]  OP_NOP   = 4'b1100;
  localparam logic [OP_W-1:0]  OP_END   = 4'b1111;
  localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, {(INSTR_W-OP_W){1'b0}}};

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      fpc_q, fpc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [PC_W-1:0]      ir_pc_q, ir_pc_d;
  logic                 ir_vld_q, ir_vld_d;
  logic                 load_valid;

  // Next-state and IF/ID load decisions.
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_vld_d   = ir_vld_q;
    load_valid = 1'b0;

    if (flush) begin
      // Redirect wins over stall and cancels a speculative halt.
      fpc_d    = branch_target;
      ir_d     = NOP_WORD;
      ir_pc_d  = '0;
      ir_vld_d = 1'b0;
      state_d  = ST_FETCH;
    end else if (!stall) begin
      case (state_q)
        ST_FETCH: begin
          ir_d       = imem_rdata;
          ir_pc_d    = fpc_q;
          ir_vld_d   = 1'b1;
          load_valid = 1'b1;
          if (imem_rdata[INSTR_W-1 -: OP_W] == OP_END) begin
            state_d = ST_HALTED;
          end else begin
            fpc_d = fpc_q + PC_W'(1);
          end
        end
        ST_HALTED: begin
          ir_d     = NOP_WORD;
          ir_vld_d = 1'b0;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Pipeline and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      fpc_q    <= RESET_PC;
      ir_q     <= NOP_WORD;
      ir_pc_q  <= '0;
      ir_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      ir_q     <= ir_d;
      ir_pc_q  <= ir_pc_d;
      ir_vld_q <= ir_vld_d;
    end
  end

  assign imem_addr = fpc_q;
  assign instr_d   = ir_q;
  assign pc_d      = ir_pc_q;
  assign valid_d   = ir_vld_q;
  assign operation = ir_q[INSTR_W-1 -: OP_W];
  assign imm       = ir_q[INSTR_W-OP_W-1];
  assign halted    = (state_q == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counters; both wrap naturally at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_valid) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (flush)      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a
// behavioural reference model. Counter ports are checked when FETCH_PERF_CNT_EN
// is defined.
module tb_fetch_stage;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] NOP_W   = 32'hC000_0000;
  localparam logic [31:0] END_W   = 32'hF000_0000;

  logic               clk;
  logic               rst;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               flush;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] instr_d;
  logic [PC_W-1:0]    pc_d;
  logic               valid_d;
  logic [3:0]         operation;
  logic               imm;
  logic               halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_fetch_cnt;
  logic [31:0]        perf_flush_cnt;
`endif

  logic [31:0] mem [0:65535];

  int vectors;
  int miscompares;

  // Reference model state.
  logic [15:0] m_pc;
  logic [31:0] m_instr;
  logic [15:0] m_pcd;
  logic        m_valid;
  logic        m_halted;
  logic [31:0] m_fcnt;
  logic [31:0] m_xcnt;

  fetch_stage #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .flush        (flush),
    .branch_target(branch_target),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .valid_d      (valid_d),
    .operation    (operation),
    .imm          (imm),
    .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("instr_d",   instr_d,        m_instr);
    chk("pc_d",      32'(pc_d),      32'(m_pcd));
    chk("valid_d",   32'(valid_d),   32'(m_valid));
    chk("operation", 32'(operation), 32'(m_instr[31:28]));
    chk("imm",       32'(imm),       32'(m_instr[27]));
    chk("halted",    32'(halted),    32'(m_halted));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
    chk("perf_flush_cnt", perf_flush_cnt, m_xcnt);
`endif
  endtask

  // One clock: apply inputs, advance the model on the edge, compare after it.
  task automatic step(input logic r, input logic f, input logic s, input logic [15:0] bt);
    logic [31:0] w;
    rst = r; flush = f; stall = s; branch_target = bt;
    w = mem[m_pc];
    @(posedge clk);
    if (r) begin
      m_pc = 16'h0000; m_instr = NOP_W; m_pcd = 16'h0000; m_valid = 1'b0;
      m_halted = 1'b0; m_fcnt = 0; m_xcnt = 0;
    end else if (f) begin
      m_pc = bt; m_instr = NOP_W; m_pcd = 16'h0000; m_valid = 1'b0;
      m_halted = 1'b0; m_xcnt = m_xcnt + 1;
    end else if (!s) begin
      if (m_halted) begin
        m_instr = NOP_W; m_valid = 1'b0;
      end else begin
        m_instr = w; m_pcd = m_pc; m_valid = 1'b1; m_fcnt = m_fcnt + 1;
        if (w[31:28] == 4'hF) m_halted = 1'b1;
        else m_pc = m_pc + 16'd1;
      end
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] plain_word();
    // Top opcode bit clear: never END or NOP.
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  initial begin
    logic [31:0] w5, w40;
    vectors = 0; miscompares = 0;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; branch_target = '0;
    m_pc = 0; m_instr = NOP_W; m_pcd = 0; m_valid = 0; m_halted = 0; m_fcnt = 0; m_xcnt = 0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h1000_0000;
    for (int i = 2; i < 7; i++) mem[i] = plain_word();
    mem[7] = END_W;
    mem[16'h40] = plain_word();
    mem[16'h80] = END_W;
    mem[16'h90] = plain_word();
    mem[16'hFFFF] = plain_word();
    mem[16'h0000] = 32'h0000_0000;
    w5 = mem[5]; w40 = mem[16'h40];

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("rst_addr",  32'(imem_addr), 32'h0);
    chk("rst_valid", 32'(valid_d),   32'h0);
    chk("rst_op",    32'(operation), 32'hC);

    // First two fetches.
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("fetch1_instr", instr_d,         32'h1000_0000);
    chk("fetch1_op",    32'(operation),  32'h1);
    chk("fetch1_pcd",   32'(pc_d),       32'h1);
    chk("fetch1_addr",  32'(imem_addr),  32'h2);

    // Advance to pc=5, then stall 3 cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h1234);
      chk("stall_addr", 32'(imem_addr), 32'h5);
      chk("stall_pcd",  32'(pc_d),      32'h4);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("unstall_instr", instr_d,        w5);
    chk("unstall_addr",  32'(imem_addr), 32'h6);

    // END at address 7.
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("end_op",     32'(operation), 32'hF);
    chk("end_valid",  32'(valid_d),   32'h1);
    chk("end_addr",   32'(imem_addr), 32'h7);
    chk("end_halted", 32'(halted),    32'h1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0);
      chk("halt_valid", 32'(valid_d),   32'h0);
      chk("halt_addr",  32'(imem_addr), 32'h7);
    end

    // Flush out of halt.
    step(1'b0, 1'b1, 1'b0, 16'h0003);
    chk("unhalt_halted", 32'(halted),    32'h0);
    chk("unhalt_addr",   32'(imem_addr), 32'h3);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("resume_pcd", 32'(pc_d), 32'h3);

    // Flush overrides stall.
    step(1'b0, 1'b1, 1'b1, 16'h0040);
    chk("fls_addr",  32'(imem_addr), 32'h40);
    chk("fls_valid", 32'(valid_d),   32'h0);
    chk("fls_op",    32'(operation), 32'hC);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("fls_load", instr_d, w40);

    // Flush while the fetched word is END: no halt.
    step(1'b0, 1'b1, 1'b0, 16'h0080);
    step(1'b0, 1'b1, 1'b0, 16'h0090);
    chk("endflush_halted", 32'(halted),    32'h0);
    chk("endflush_addr",   32'(imem_addr), 32'h90);

    // Reset wins over flush.
    step(1'b1, 1'b1, 1'b0, 16'h0055);
    chk("rstflush_addr", 32'(imem_addr), 32'h0);

    // PC wrap.
    step(1'b0, 1'b1, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("wrap_addr", 32'(imem_addr), 32'h0);
    chk("wrap_pcd",  32'(pc_d),      32'hFFFF);

    // Counter example: 4 fetches and 1 flush after reset.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    mem[0] = plain_word(); mem[1] = plain_word(); mem[2] = plain_word(); mem[3] = plain_word();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0010);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt_fetch", perf_fetch_cnt, 32'd4);
    chk("cnt_flush", perf_flush_cnt, 32'd1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic r, f, s;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 10);
      s = ($urandom_range(0, 99) < 25);
      step(r, f, s, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
